avm_rd_arbiter: RTL and testbench

- Shares one 16-bit Avalon-MM read master (avm_m0_*) among NCLIENTS requesters, typically multiple tri_reader instances feeding parallel ray units.
- Round-robin arbitration on the request side.
- Tracks outstanding reads in an in-order tag FIFO so each readdatavalid beat routes back to the client that issued it.
- Read-only; write channel tied off.

---
 rtl/avm_rd_arbiter.sv | 125 ++++++++++++
 tb/tb_avm_rd_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avm_rd_arbiter.sv
// Round-robin read arbiter sharing one Avalon-MM read master among
// NCLIENTS requesters, with an in-order tag FIFO to route return beats.
// Ports: clk/reset (async, active-high); c_read/c_address/c_waitrequest
// request side per client; c_readdata (broadcast) + c_readdatavalid
// (one-hot) return side; avm_m0_* Avalon master (write channel tied off);
// pend_count = outstanding reads; proto_err = sticky orphan-return flag.
module avm_rd_arbiter #(
    parameter int NCLIENTS = 4,
    parameter int MAXPEND  = 8,
    parameter int AW       = 32,
    parameter int DW       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCLIENTS-1:0]        c_read,
    input  logic [NCLIENTS*AW-1:0]     c_address,
    output logic [NCLIENTS-1:0]        c_waitrequest,
    output logic [DW-1:0]              c_readdata,
    output logic [NCLIENTS-1:0]        c_readdatavalid,
    output logic                       avm_m0_read,
    output logic [AW-1:0]              avm_m0_address,
    input  logic [DW-1:0]              avm_m0_readdata,
    input  logic                       avm_m0_readdatavalid,
    input  logic                       avm_m0_waitrequest,
    output logic                       avm_m0_write,
    output logic [DW-1:0]              avm_m0_writedata,
    output logic [DW/8-1:0]            avm_m0_byteenable,
    output logic [$clog2(MAXPEND):0]   pend_count,
    output logic                       proto_err
);

    localparam int IW = $clog2(NCLIENTS);
    localparam int PW = $clog2(MAXPEND);
    localparam int CW = PW + 1;
    localparam logic [NCLIENTS-1:0] ONE = 1;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] locked_id;
    logic [IW-1:0] grant;
    logic          lock;
    logic          no_req;
    logic          full;
    logic          accept;
    logic          pop;
    logic [IW-1:0] tags [MAXPEND];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // A stalled request keeps its grant so address/read stay stable
    // until the slave accepts it.
    always_comb begin
        grant  = locked_id;
        no_req = 1'b0;
        if (!lock) begin
            grant  = '0;
            no_req = 1'b1;
            for (int k = 1; k <= NCLIENTS; k++) begin
                if (no_req && c_read[(int'(rr_ptr) + k) % NCLIENTS]) begin
                    grant  = IW'((int'(rr_ptr) + k) % NCLIENTS);
                    no_req = 1'b0;
                end
            end
        end
    end

    assign full = (pend_count == CW'(MAXPEND));

    // Gated by reset so the master read drops the moment reset asserts,
    // even while clients keep c_read high.
    assign avm_m0_read    = !reset && (lock || (!no_req && !full));
    assign avm_m0_address = c_address[grant*AW +: AW];
    assign accept         = avm_m0_read && !avm_m0_waitrequest;
    assign pop            = avm_m0_readdatavalid && (pend_count != '0);

    always_comb begin
        for (int i = 0; i < NCLIENTS; i++) begin
            c_waitrequest[i] = !(accept && grant == IW'(i));
        end
    end

    assign avm_m0_write      = 1'b0;
    assign avm_m0_writedata  = '0;
    assign avm_m0_byteenable = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr          <= IW'(NCLIENTS - 1);
            lock            <= 1'b0;
            locked_id       <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            pend_count      <= '0;
            proto_err       <= 1'b0;
            c_readdatavalid <= '0;
            c_readdata      <= '0;
        end else begin
            if (accept) begin
                lock   <= 1'b0;
                rr_ptr <= grant;
                wr_ptr <= wr_ptr + 1'b1;
            end else if (avm_m0_read) begin
                lock      <= 1'b1;
                locked_id <= grant;
            end
            pend_count <= pend_count + CW'(accept) - CW'(pop);
            c_readdatavalid <= '0;
            if (pop) begin
                rd_ptr          <= rd_ptr + 1'b1;
                c_readdata      <= avm_m0_readdata;
                c_readdatavalid <= ONE << tags[rd_ptr];
            end
            // A beat with nothing outstanding has no owner: drop and flag.
            if (avm_m0_readdatavalid && !pop) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tags[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_avm_rd_arbiter.sv
// Scoreboard testbench for avm_rd_arbiter: random clients and a random
// in-order memory, checked against a high-level arbitration model.
module tb_avm_rd_arbiter;

    localparam int NC = 4;
    localparam int MP = 8;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int CW = $clog2(MP) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NC-1:0]     c_read = '0;
    logic [NC*AW-1:0]  c_address = '0;
    logic [NC-1:0]     c_waitrequest;
    logic [DW-1:0]     c_readdata;
    logic [NC-1:0]     c_readdatavalid;
    logic              avm_m0_read;
    logic [AW-1:0]     avm_m0_address;
    logic [DW-1:0]     avm_m0_readdata = '0;
    logic              avm_m0_readdatavalid = 1'b0;
    logic              avm_m0_waitrequest = 1'b0;
    logic              avm_m0_write;
    logic [DW-1:0]     avm_m0_writedata;
    logic [DW/8-1:0]   avm_m0_byteenable;
    logic [CW-1:0]     pend_count;
    logic              proto_err;

    avm_rd_arbiter #(
        .NCLIENTS(NC), .MAXPEND(MP), .AW(AW), .DW(DW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .c_read               (c_read),
        .c_address            (c_address),
        .c_waitrequest        (c_waitrequest),
        .c_readdata           (c_readdata),
        .c_readdatavalid      (c_readdatavalid),
        .avm_m0_read          (avm_m0_read),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_readdata      (avm_m0_readdata),
        .avm_m0_readdatavalid (avm_m0_readdatavalid),
        .avm_m0_waitrequest   (avm_m0_waitrequest),
        .avm_m0_write         (avm_m0_write),
        .avm_m0_writedata     (avm_m0_writedata),
        .avm_m0_byteenable    (avm_m0_byteenable),
        .pend_count           (pend_count),
        .proto_err            (proto_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Scoreboard entries: {client id, data}, in issue order.
    logic [18:0] sb_q [$];
    logic [15:0] mem_q [$];
    int          mem_due [$];
    logic [18:0] mon_e;

    int          model_pend = 0;
    int          last_id = NC - 1;
    int          held_id = 0;
    bit          held = 1'b0;
    logic [NC-1:0] req = '0;
    logic [NC-1:0] en = '0;
    logic [AW-1:0] addr [NC];
    bit          mem_ret_en = 1'b1;
    int          stall_pct = 0;
    int          req_pct = 50;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] fdat(logic [AW-1:0] a);
        return a[15:0] ^ a[31:16] ^ 16'h3c5a;
    endfunction

    function automatic int rr_pick();
        for (int k = 1; k <= NC; k++) begin
            if (c_read[(last_id + k) % NC]) return (last_id + k) % NC;
        end
        return 0;
    endfunction

    task automatic drive_clients();
        for (int i = 0; i < NC; i++) c_address[i*AW +: AW] = addr[i];
        c_read = req;
    endtask

    task automatic model_reset();
        sb_q.delete();
        mem_q.delete();
        mem_due.delete();
        model_pend = 0;
        last_id = NC - 1;
        held = 1'b0;
        req = '0;
        drive_clients();
    endtask

    // One clock: check registered state, drive memory and clients, then
    // check the combinational issue path just before the next edge.
    task automatic step();
        bit ret;
        bit exp_rd;
        bit exp_acc;
        int g;
        logic [NC-1:0] exp_wr;
        @(negedge clk);
        cyc++;
        chk("pend_count", pend_count, model_pend);
        ret = 1'b0;
        if (mem_ret_en && mem_q.size() != 0 && mem_due[0] <= cyc
            && $urandom_range(0, 3) != 0) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata = mem_q.pop_front();
            void'(mem_due.pop_front());
            ret = 1'b1;
        end else begin
            avm_m0_readdatavalid = 1'b0;
            avm_m0_readdata = 16'($urandom);
        end
        avm_m0_waitrequest = ($urandom_range(0, 99) < stall_pct);
        for (int i = 0; i < NC; i++) begin
            if (en[i] && !req[i] && $urandom_range(0, 99) < req_pct) begin
                req[i] = 1'b1;
                addr[i] = {29'($urandom), 3'(i)};
            end
        end
        drive_clients();
        #1;
        g = held ? held_id : rr_pick();
        exp_rd = held || (c_read != '0 && model_pend < MP);
        exp_acc = exp_rd && !avm_m0_waitrequest;
        exp_wr = '1;
        if (exp_acc) exp_wr[g] = 1'b0;
        chk("avm_m0_read", avm_m0_read, exp_rd);
        chk("c_waitrequest", c_waitrequest, exp_wr);
        if (exp_rd) chk("avm_m0_address", avm_m0_address, addr[g]);
        if (avm_m0_read && !avm_m0_waitrequest) begin
            mem_q.push_back(fdat(avm_m0_address));
            mem_due.push_back(cyc + 1 + int'($urandom_range(0, 3)));
        end
        if (exp_acc) begin
            sb_q.push_back({3'(g), fdat(addr[g])});
            model_pend++;
            last_id = g;
            req[g] = 1'b0;
            held = 1'b0;
        end else if (exp_rd) begin
            held = 1'b1;
            held_id = g;
        end
        if (ret && model_pend > 0) model_pend--;
    endtask

    task automatic drain();
        int n;
        n = 0;
        en = '0;
        while ((model_pend > 0 || req != '0 || mem_q.size() != 0)
               && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got pend=%0d expected 0", model_pend);
        end
        repeat (3) step();
    endtask

    task automatic stale_pulse();
        @(negedge clk);
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata = 16'hdead;
        @(negedge clk);
        avm_m0_readdatavalid = 1'b0;
        chk("stale_proto_err", proto_err, 1);
        chk("stale_no_strobe", c_readdatavalid, 0);
        chk("stale_pend", pend_count, 0);
        @(negedge clk);
        chk("proto_err_sticky", proto_err, 1);
    endtask

    always @(negedge clk) begin
        if (!reset && c_readdatavalid != '0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got %b expected none",
                         c_readdatavalid);
            end else begin
                mon_e = sb_q.pop_front();
                chk("strobe", c_readdatavalid, 64'(1) << mon_e[18:16]);
                chk("readdata", c_readdata, mon_e[15:0]);
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < NC; i++) addr[i] = '0;
        c_read = '1;
        repeat (3) @(negedge clk);
        chk("rst_read", avm_m0_read, 0);
        chk("rst_wait", c_waitrequest, {NC{1'b1}});
        chk("rst_pend", pend_count, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_rdv", c_readdatavalid, 0);
        chk("rst_rdata", c_readdata, 0);
        chk("tie_write", avm_m0_write, 0);
        chk("tie_wdata", avm_m0_writedata, 0);
        chk("tie_be", avm_m0_byteenable, {(DW/8){1'b1}});
        c_read = '0;
        reset = 1'b0;

        // Single client, address 0x10, no stall.
        stall_pct = 0;
        mem_ret_en = 1'b1;
        req[0] = 1'b1;
        addr[0] = 32'h10;
        step();
        drain();

        // Orphan return beat.
        stale_pulse();

        // Build outstanding reads, then reset mid-operation.
        mem_ret_en = 1'b0;
        en = 4'b0010;
        req_pct = 100;
        n = 0;
        while (model_pend < 3 && n < 50) begin
            step();
            n++;
        end
        en = '0;
        chk("pre_rst_pend", pend_count >= 2, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_read", avm_m0_read, 0);
        chk("async_rst_wait", c_waitrequest, {NC{1'b1}});
        chk("async_rst_pend", pend_count, 0);
        chk("async_rst_proto", proto_err, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        stale_pulse();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_clears_err", proto_err, 0);

        // Random traffic with stalls.
        mem_ret_en = 1'b1;
        en = '1;
        req_pct = 60;
        stall_pct = 30;
        repeat (600) step();

        // Saturated round-robin, no stalls.
        req_pct = 100;
        stall_pct = 0;
        repeat (200) step();

        // No returns: fill to MAXPEND and hold there.
        mem_ret_en = 1'b0;
        stall_pct = 20;
        repeat (40) step();
        mem_ret_en = 1'b1;
        repeat (150) step();

        drain();
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
